// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and defaults for the pipeline skid stage.
// The state enum mirrors {m_v,s_v} and is used only for decode, assertions and debug.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_ONE,
        PS_FULL
    } pipe_state_t;

    localparam int PIPE_DATA_W_DFLT = 160;

    function automatic pipe_state_t pipe_state(input logic m_v, input logic s_v);
        if (!m_v) begin
            return PS_EMPTY;
        end
        return s_v ? PS_FULL : PS_ONE;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_cnt.sv
// Saturating up-counter with synchronous clear, used for the optional stage perf counters.
module pipe_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline boundary register with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters perf_full/perf_flush are present when PIPE_STAGE_PERF_EN is defined.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W      = PIPE_DATA_W_DFLT,
    parameter bit ZERO_ON_INV = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_full,
    output logic [31:0]       perf_flush
`endif
);

    logic              m_v, s_v;
    logic [DATA_W-1:0] m_d, s_d;
    logic              m_v_nxt, s_v_nxt;
    logic [DATA_W-1:0] m_d_nxt, s_d_nxt;
    logic              put, take;
    pipe_state_t       state;

    // in_ready depends only on the skid flag and the stall, never on out_ready.
    assign in_ready  = ~s_v & ~hold;
    assign out_valid = m_v;
    assign out_data  = m_d;
    assign put       = in_valid & in_ready & ~flush;
    assign take      = m_v & out_ready & ~hold;
    assign state     = pipe_state(m_v, s_v);

    always_comb begin
        m_v_nxt = m_v;
        s_v_nxt = s_v;
        m_d_nxt = m_d;
        s_d_nxt = s_d;
        if (flush) begin
            m_v_nxt = 1'b0;
            s_v_nxt = 1'b0;
            if (ZERO_ON_INV) begin
                m_d_nxt = '0;
                s_d_nxt = '0;
            end
        end else begin
            // hold forces put and take low, so a stalled stage falls through unchanged.
            case (state)
                PS_EMPTY: begin
                    if (put) begin
                        m_v_nxt = 1'b1;
                        m_d_nxt = in_data;
                    end
                end
                PS_ONE: begin
                    if (put && take) begin
                        m_d_nxt = in_data;
                    end else if (put) begin
                        s_v_nxt = 1'b1;
                        s_d_nxt = in_data;
                    end else if (take) begin
                        m_v_nxt = 1'b0;
                        if (ZERO_ON_INV) begin
                            m_d_nxt = '0;
                        end
                    end
                end
                PS_FULL: begin
                    if (take) begin
                        m_d_nxt = s_d;
                        s_v_nxt = 1'b0;
                        if (ZERO_ON_INV) begin
                            s_d_nxt = '0;
                        end
                    end
                end
                default: begin
                    m_v_nxt = 1'b0;
                    s_v_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_d <= '0;
            s_d <= '0;
        end else begin
            m_v <= m_v_nxt;
            s_v <= s_v_nxt;
            m_d <= m_d_nxt;
            s_d <= s_d_nxt;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // A flush counts when it kills a held beat or one that would have been accepted.
    pipe_sat_cnt #(.WIDTH(32)) u_perf_full (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (m_v & s_v & ~flush),
        .clr   (1'b0),
        .count (perf_full)
    );

    pipe_sat_cnt #(.WIDTH(32)) u_perf_flush (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (flush & (m_v | (in_valid & in_ready))),
        .clr   (1'b0),
        .count (perf_flush)
    );
`endif

    a_no_orphan_skid: assert property (@(posedge clk) disable iff (!rstn)
        !(s_v && !m_v));

    a_out_stable: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: vector table, directed corner cases and a random run
// against a queue-based reference model. Perf checks compile in with PIPE_STAGE_PERF_EN.
module tb_pipe_skid_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          hold, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   perf_full, perf_flush;
`endif

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] mq[$];
    logic [31:0]   m_pfull, m_pflush;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ord;
        logic          hd;
        logic          fl;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ir;
    } vec_t;

    vec_t vecs[17];

    pipe_skid_stage #(.DATA_W(DW), .ZERO_ON_INV(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hold       (hold),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_full  (perf_full),
        .perf_flush (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic iv, input logic [DW-1:0] d, input logic ord,
                                  input logic hd, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ord;
        hold      = hd;
        flush     = fl;
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Advance the reference queue by one clock using the handshake rules, then let the DUT clock.
    task automatic tick();
        int   sz;
        logic acc, tk;
        sz  = mq.size();
        acc = in_valid && (sz < 2) && !hold;
        tk  = (sz > 0) && out_ready && !hold;
        if (sz == 2 && !flush) m_pfull = sat_inc(m_pfull);
        if (flush && (sz > 0 || acc)) m_pflush = sat_inc(m_pflush);
        if (flush) begin
            mq.delete();
        end else begin
            if (tk) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag);
        logic [DW-1:0] e_od;
        e_od = (mq.size() > 0) ? mq[0] : '0;
        check({tag, ".out_valid"}, DW'(out_valid), DW'(mq.size() > 0));
        check({tag, ".out_data"}, out_data, e_od);
        check({tag, ".in_ready"}, DW'(in_ready), DW'((mq.size() < 2) && !hold));
`ifdef PIPE_STAGE_PERF_EN
        check({tag, ".perf_full"}, DW'(perf_full), DW'(m_pfull));
        check({tag, ".perf_flush"}, DW'(perf_flush), DW'(m_pflush));
`endif
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        mq.delete();
        m_pfull  = '0;
        m_pflush = '0;
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic ord,
                                input logic hd, input logic fl, input logic e_ov,
                                input logic [DW-1:0] e_od, input logic e_ir);
        vec_t v;
        v.iv = iv; v.d = d; v.ord = ord; v.hd = hd; v.fl = fl;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
        a_d = 32'hA000_0001; b_d = 32'hB000_0002; c_d = 32'hC000_0003; d_d = 32'hD000_0004;
        e_d = 32'hE000_0005; f_d = 32'hF000_0006; g_d = 32'h1234_5678; h_d = 32'h8765_4321;

        vecs[0]  = mk(1, a_d, 0, 0, 0, 1, a_d, 1);
        vecs[1]  = mk(1, b_d, 0, 0, 0, 1, a_d, 0);
        vecs[2]  = mk(1, c_d, 0, 0, 0, 1, a_d, 0);
        vecs[3]  = mk(1, c_d, 1, 0, 0, 1, b_d, 1);
        vecs[4]  = mk(1, c_d, 1, 0, 0, 1, c_d, 1);
        vecs[5]  = mk(0, '0,  1, 0, 0, 0, '0,  1);
        vecs[6]  = mk(1, d_d, 0, 0, 0, 1, d_d, 1);
        vecs[7]  = mk(1, e_d, 0, 0, 0, 1, d_d, 0);
        vecs[8]  = mk(0, '0,  1, 1, 0, 1, d_d, 0);
        vecs[9]  = mk(0, '0,  1, 1, 0, 1, d_d, 0);
        vecs[10] = mk(0, '0,  1, 1, 0, 1, d_d, 0);
        vecs[11] = mk(0, '0,  1, 0, 0, 1, e_d, 1);
        vecs[12] = mk(0, '0,  1, 0, 0, 0, '0,  1);
        vecs[13] = mk(1, f_d, 0, 0, 0, 1, f_d, 1);
        vecs[14] = mk(1, g_d, 0, 0, 0, 1, f_d, 0);
        vecs[15] = mk(1, h_d, 1, 1, 1, 0, '0,  0);
        vecs[16] = mk(0, '0,  1, 0, 0, 0, '0,  1);

        rstn = 1'b0;
        apply_stimulus(0, '0, 0, 0, 0);
        mq.delete();
        m_pfull  = '0;
        m_pflush = '0;
        #12;
        rstn = 1'b1;
        #1;
        check("reset.out_valid", DW'(out_valid), '0);
        check("reset.out_data", out_data, '0);
        check("reset.in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;

        // Backpressure, hold and flush-race sequences from the vector table.
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].iv, vecs[i].d, vecs[i].ord, vecs[i].hd, vecs[i].fl);
            tick();
            check($sformatf("vec%0d.out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
            check($sformatf("vec%0d.out_data", i), out_data, vecs[i].e_od);
            check($sformatf("vec%0d.in_ready", i), DW'(in_ready), DW'(vecs[i].e_ir));
        end

        // Reset mid-stream from FULL.
        apply_stimulus(1, 32'h0000_0AAA, 0, 0, 0);
        tick();
        apply_stimulus(1, 32'h0000_0BBB, 0, 0, 0);
        tick();
        check("pre_rst.in_ready", DW'(in_ready), '0);
        #2;
        rstn = 1'b0;
        mq.delete();
        m_pfull  = '0;
        m_pflush = '0;
        #1;
        check("rst_async.out_valid", DW'(out_valid), '0);
        check("rst_async.out_data", out_data, '0);
        @(posedge clk);
        #4;
        rstn = 1'b1;
        apply_stimulus(1, 32'h0000_0CCC, 1, 0, 0);
        #1;
        check("rst_rel.in_ready", DW'(in_ready), DW'(1));
        check("rst_rel.out_valid", DW'(out_valid), '0);
        @(posedge clk);
        #1;
        mq.push_back(32'h0000_0CCC);
        check("rst_first.out_valid", DW'(out_valid), DW'(1));
        check("rst_first.out_data", out_data, 32'h0000_0CCC);
        apply_stimulus(0, '0, 1, 0, 0);
        tick();
        check_output("rst_drain");

        // Back-to-back streaming, one beat per cycle.
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus(1, DW'(i), 1, 0, 0);
            tick();
            check($sformatf("stream%0d.out_data", i), out_data, DW'(i));
            check($sformatf("stream%0d.in_ready", i), DW'(in_ready), DW'(1));
        end
        apply_stimulus(0, '0, 1, 0, 0);
        tick();
        check_output("stream_end");

`ifdef PIPE_STAGE_PERF_EN
        do_reset();
        apply_stimulus(1, 32'h0000_1111, 0, 0, 0);
        tick();
        apply_stimulus(1, 32'h0000_2222, 0, 0, 0);
        tick();
        apply_stimulus(0, '0, 1, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        check("perf.full5", DW'(perf_full), DW'(5));
        apply_stimulus(1, 32'h0000_3333, 1, 1, 1);
        tick();
        check("perf.flush1", DW'(perf_flush), DW'(1));
        check_output("perf_flush");
        apply_stimulus(1, 32'h0000_4444, 0, 0, 0);
        tick();
        apply_stimulus(1, 32'h0000_5555, 0, 0, 0);
        tick();
        apply_stimulus(0, '0, 0, 1, 0);
        #2;
        force dut.u_perf_full.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_perf_full.count;
        m_pfull = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) tick();
        check("perf.sat", DW'(perf_full), DW'(32'hFFFF_FFFF));
        check_output("perf_sat");
`endif

        // Random traffic against the reference queue.
        do_reset();
        check_output("rand_rst");
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(($urandom_range(0, 3) != 0), DW'($urandom),
                           ($urandom_range(0, 1) != 0), ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 31) == 0));
            tick();
            check_output($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
